// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter that shares one axi_lite_master among N_REQ requesters.
// Latches the winner's request fields, runs the master's start/done handshake
// and returns read data with a one-cycle ack to the granted requester.
module axi_lite_req_arbiter #(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned ID_W  = $clog2(N_REQ),
    localparam int unsigned DW    = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_mode,
    input  logic [DW*N_REQ-1:0] req_addr,
    input  logic [DW*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       ack_rdata,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    output logic [CNT_W-1:0]    txn_count,
    output logic                m_start,
    output logic                m_mode,
    output logic [DW-1:0]       m_addr,
    output logic [DW-1:0]       m_wdata,
    input  logic [DW-1:0]       m_rdata,
    input  logic                m_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               m_start_q, m_start_d;
    logic               m_mode_q, m_mode_d;
    logic [DW-1:0]      m_addr_q, m_addr_d;
    logic [DW-1:0]      m_wdata_q, m_wdata_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [DW-1:0]      ack_rdata_q, ack_rdata_d;
    logic [CNT_W-1:0]   txn_count_q, txn_count_d;
    logic               busy_q, busy_d;

    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    cand;

    // Round-robin scan: first asserted req at rr_ptr, rr_ptr+1, ... (mod N_REQ).
    // Scanning from the far end lets the closest candidate overwrite the others.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % int'(N_REQ));
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output computation for the grant sequencer.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        m_start_d   = 1'b0;
        m_mode_d    = m_mode_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        ack_d       = '0;
        ack_rdata_d = ack_rdata_q;
        txn_count_d = txn_count_q;

        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d    = S_ISSUE;
                    grant_id_d = win_idx;
                    m_mode_d   = req_mode[win_idx];
                    m_addr_d   = req_addr[DW*win_idx +: DW];
                    m_wdata_d  = req_wdata[DW*win_idx +: DW];
                    m_start_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    state_d     = S_RESP;
                    ack_rdata_d = m_rdata;
                    txn_count_d = txn_count_q + CNT_W'(1);
                    rr_ptr_d    = (grant_id_q == ID_W'(N_REQ - 1)) ? '0
                                                                   : grant_id_q + ID_W'(1);
                    ack_d       = N_REQ'(1) << grant_id_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            m_start_q   <= 1'b0;
            m_mode_q    <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            ack_q       <= '0;
            ack_rdata_q <= '0;
            txn_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            m_start_q   <= m_start_d;
            m_mode_q    <= m_mode_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            ack_q       <= ack_d;
            ack_rdata_q <= ack_rdata_d;
            txn_count_q <= txn_count_d;
            busy_q      <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign ack_rdata = ack_rdata_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign txn_count = txn_count_q;
    assign m_start   = m_start_q;
    assign m_mode    = m_mode_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

endmodule
